// File: rtl/rs_syndrome_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : rs_syndrome_ctrl
//  Purpose  : Framed Reed-Solomon syndrome generator. Runs CHECK parallel
//             Horner accumulators (one constant GF multiply each), checks the
//             codeword length and hands the syndrome vector to the
//             key-equation solver through a valid/ack handshake.
//  Revision : 1.0  initial release
// ============================================================================
module rs_syndrome_ctrl #(
  parameter int M         = 8,    // symbol width
  parameter int IRRPOL    = 285,  // field generator polynomial
  parameter int N         = 255,  // codeword length in symbols
  parameter int CHECK     = 32,   // number of syndromes (2t)
  parameter int GEN_START = 0     // power of first generator root
) (
  input  logic               iclk,
  input  logic               ireset_n,
  input  logic               iclkena,
  input  logic               isop,
  input  logic               ieop,
  input  logic               ival,
  input  logic [M-1:0]       idat,
  output logic               ordy,
  output logic               osyn_val,
  output logic [CHECK*M-1:0] osyn,
  output logic               osyn_zero,
  output logic               oerr_len,
  input  logic               iack
);

  localparam int CW = $clog2(N + 1);
  localparam int W  = CHECK * M;

  localparam logic [M-1:0]  c_poly    = IRRPOL[M-1:0];
  localparam int            c_order   = (1 << M) - 1;
  localparam logic [CW-1:0] c_cnt_max = '1;
  localparam logic [CW-1:0] c_len     = CW'(N);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  // GF(2^M) multiply, shift-and-add with reduction by the field polynomial
  function automatic logic [M-1:0] gf_mult(input logic [M-1:0] a, input logic [M-1:0] b);
    logic [M-1:0] p;
    logic [M-1:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < M; i++) begin
      if (b[i]) p = p ^ x;
      x = x[M-1] ? ((x << 1) ^ c_poly) : (x << 1);
    end
    return p;
  endfunction

  // alpha^e, evaluated at elaboration time for the per-syndrome root constants
  function automatic logic [M-1:0] gf_pow(input int e);
    logic [M-1:0] r;
    int           ee;
    ee = e % c_order;
    r  = M'(1);
    for (int i = 0; i < ee; i++) r = gf_mult(r, M'(2));
    return r;
  endfunction

  state_t        state_q, state_d;
  logic [W-1:0]  acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ovf_q, ovf_d;     // sticky: frame ran past the counter ceiling
  logic [W-1:0]  osyn_q, osyn_d;
  logic          osyn_val_q, osyn_val_d;
  logic          osyn_zero_q, osyn_zero_d;
  logic          oerr_len_q, oerr_len_d;

  logic          w_accept;
  logic          w_start;
  logic          w_step;
  logic          w_leave;
  logic [W-1:0]  w_acc_upd;
  logic [W-1:0]  w_acc_new;
  logic [CW-1:0] w_cnt_new;
  logic          w_ovf_new;

  // ready unless a result is parked and not being acknowledged this cycle
  assign ordy     = (state_q != ST_HOLD) | iack;
  assign w_accept = iclkena & ival & ordy;

  // one Horner step per syndrome: S_j * alpha^(GEN_START+j) + idat
  for (genvar j = 0; j < CHECK; j++) begin : g_syn
    localparam logic [M-1:0] c_root = gf_pow(GEN_START + j);
    assign w_acc_upd[j*M +: M] = gf_mult(acc_q[j*M +: M], c_root) ^ idat;
  end

  // frame sequencing, accumulator and result next-state
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    osyn_d      = osyn_q;
    osyn_val_d  = osyn_val_q;
    osyn_zero_d = osyn_zero_q;
    oerr_len_d  = oerr_len_q;
    w_start     = 1'b0;
    w_step      = 1'b0;
    w_leave     = 1'b0;

    if (iclkena) begin
      case (state_q)
        ST_IDLE: begin
          w_start = w_accept & isop;
        end
        ST_ACC: begin
          w_start = w_accept & isop;
          w_step  = w_accept & ~isop;
        end
        ST_HOLD: begin
          w_leave = iack;
          w_start = iack & w_accept & isop;
        end
        default: begin
          w_leave = 1'b1;
        end
      endcase
    end

    w_acc_new = w_start ? {CHECK{idat}} : w_acc_upd;
    w_cnt_new = w_start ? CW'(1) : ((cnt_q == c_cnt_max) ? cnt_q : cnt_q + CW'(1));
    w_ovf_new = w_start ? 1'b0 : (ovf_q | (cnt_q == c_cnt_max));

    if (w_leave) begin
      state_d    = ST_IDLE;
      osyn_val_d = 1'b0;
    end

    if (w_start || w_step) begin
      acc_d   = w_acc_new;
      cnt_d   = w_cnt_new;
      ovf_d   = w_ovf_new;
      state_d = ieop ? ST_HOLD : ST_ACC;
      if (ieop) begin
        osyn_d      = w_acc_new;
        osyn_zero_d = ~|w_acc_new;
        oerr_len_d  = (w_cnt_new != c_len) | w_ovf_new;
        osyn_val_d  = 1'b1;
      end
    end
  end

  // state and result registers, asynchronously cleared
  always_ff @(posedge iclk or negedge ireset_n) begin
    if (!ireset_n) begin
      state_q     <= ST_IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      osyn_q      <= '0;
      osyn_val_q  <= 1'b0;
      osyn_zero_q <= 1'b0;
      oerr_len_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      osyn_q      <= osyn_d;
      osyn_val_q  <= osyn_val_d;
      osyn_zero_q <= osyn_zero_d;
      oerr_len_q  <= oerr_len_d;
    end
  end

  assign osyn      = osyn_q;
  assign osyn_val  = osyn_val_q;
  assign osyn_zero = osyn_zero_q;
  assign oerr_len  = oerr_len_q;

endmodule
`default_nettype wire

// File: tb/tb_rs_syndrome_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rs_syndrome_ctrl
//  Purpose  : Self-checking bench for rs_syndrome_ctrl (m=8, n=255, 2t=32).
//             Table of framed codewords plus hand-written handshake, restart,
//             reset-abort and clock-enable sequences.
//  Revision : 1.0  initial release
// ============================================================================
module tb_rs_syndrome_ctrl;

  localparam int M         = 8;
  localparam int N         = 255;
  localparam int CHECK     = 32;
  localparam int GEN_START = 0;
  localparam int W         = M * CHECK;

  logic         iclk     = 1'b0;
  logic         ireset_n = 1'b0;
  logic         iclkena  = 1'b1;
  logic         isop     = 1'b0;
  logic         ieop     = 1'b0;
  logic         ival     = 1'b0;
  logic [M-1:0] idat     = '0;
  logic         iack     = 1'b1;
  logic         ordy;
  logic         osyn_val;
  logic [W-1:0] osyn;
  logic         osyn_zero;
  logic         oerr_len;

  rs_syndrome_ctrl #(
    .M(M), .IRRPOL(285), .N(N), .CHECK(CHECK), .GEN_START(GEN_START)
  ) dut (
    .iclk(iclk), .ireset_n(ireset_n), .iclkena(iclkena),
    .isop(isop), .ieop(ieop), .ival(ival), .idat(idat),
    .ordy(ordy), .osyn_val(osyn_val), .osyn(osyn),
    .osyn_zero(osyn_zero), .oerr_len(oerr_len), .iack(iack)
  );

  always #5 iclk = ~iclk;

  int           n_chk = 0;
  int           n_fail = 0;
  bit           en_rand = 1'b0;
  logic [7:0]   fr [0:511];
  int           exp_t [0:254];
  int           log_t [0:255];

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // log/antilog multiply over GF(256), poly 0x11D
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    if (a == 0 || b == 0) return 8'h00;
    return 8'(exp_t[(log_t[a] + log_t[b]) % 255]);
  endfunction

  // direct evaluation: S_j = sum_i c_i * alpha^((GEN_START+j)*(L-1-i))
  function automatic logic [W-1:0] ref_syn(input int L);
    logic [W-1:0] r;
    logic [7:0]   s;
    r = '0;
    for (int j = 0; j < CHECK; j++) begin
      s = 8'h00;
      for (int i = 0; i < L; i++)
        s = s ^ gmul(fr[i], 8'(exp_t[((GEN_START + j) * (L - 1 - i)) % 255]));
      r[j*8 +: 8] = s;
    end
    return r;
  endfunction

  task automatic step();
    @(posedge iclk);
    #1;
  endtask

  // present one symbol until it is accepted (bounded)
  task automatic drive_sym(input logic [7:0] d, input logic s, input logic e);
    int guard;
    bit done;
    guard = 0;
    done  = 1'b0;
    ival = 1'b1; idat = d; isop = s; ieop = e;
    while (!done) begin
      iclkena = en_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      done = iclkena && ordy;
      step();
      guard++;
      if (!done && guard > 200) begin
        n_chk++; n_fail++;
        $display("FAIL drive_timeout: symbol not accepted after %0d cycles, required acceptance", guard);
        done = 1'b1;
      end
    end
    ival = 1'b0; isop = 1'b0; ieop = 1'b0; iclkena = 1'b1;
  endtask

  task automatic send_frame(input int L);
    for (int i = 0; i < L; i++)
      drive_sym(fr[i], i == 0, i == L - 1);
  endtask

  task automatic fill(input int kind, input int L);
    for (int i = 0; i < 512; i++) fr[i] = 8'h00;
    case (kind)
      1: fr[L-1] = 8'h05;
      2: fr[0]   = 8'h01;
      3: for (int i = 0; i < L; i++) fr[i] = 8'($urandom);
      4: fr[0]   = 8'h37;
      default: ;
    endcase
  endtask

  task automatic chk_result(input string tag, input int L, input logic err);
    logic [W-1:0] r;
    r = ref_syn(L);
    chk({tag, "_val"},  W'(osyn_val),  W'(1'b1));
    chk({tag, "_err"},  W'(oerr_len),  W'(err));
    chk({tag, "_zero"}, W'(osyn_zero), W'(~|r));
    chk({tag, "_syn"},  osyn,          r);
  endtask

  typedef struct {
    int         len;
    int         kind;
    logic       exp_err;
    logic       hand;
    logic [7:0] s0;
    logic [7:0] s1;
  } vec_t;

  vec_t tbl [8];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] r1;
    int x;

    x = 1;
    for (int i = 0; i < 255; i++) begin
      exp_t[i] = x;
      log_t[x] = i;
      x = x << 1;
      if (x > 255) x = x ^ 'h11D;
    end
    log_t[0] = 0;

    tbl[0] = '{255, 0, 1'b0, 1'b1, 8'h00, 8'h00};
    tbl[1] = '{255, 1, 1'b0, 1'b1, 8'h05, 8'h05};
    tbl[2] = '{255, 2, 1'b0, 1'b1, 8'h01, 8'h8E};
    tbl[3] = '{100, 3, 1'b1, 1'b0, 8'h00, 8'h00};
    tbl[4] = '{300, 0, 1'b1, 1'b1, 8'h00, 8'h00};
    tbl[5] = '{1,   4, 1'b1, 1'b1, 8'h37, 8'h37};
    tbl[6] = '{255, 3, 1'b0, 1'b0, 8'h00, 8'h00};
    tbl[7] = '{256, 0, 1'b1, 1'b1, 8'h00, 8'h00};

    // reset state
    step(); step();
    chk("rst_val",  W'(osyn_val),  W'(1'b0));
    chk("rst_syn",  osyn,          '0);
    chk("rst_zero", W'(osyn_zero), W'(1'b0));
    chk("rst_err",  W'(oerr_len),  W'(1'b0));
    chk("rst_rdy",  W'(ordy),      W'(1'b1));
    ireset_n = 1'b1;
    step();

    // table of framed codewords, iack held high
    for (int k = 0; k < 8; k++) begin
      fill(tbl[k].kind, tbl[k].len);
      send_frame(tbl[k].len);
      chk_result($sformatf("tbl%0d", k), tbl[k].len, tbl[k].exp_err);
      if (tbl[k].hand) begin
        chk($sformatf("tbl%0d_s0", k), W'(osyn[7:0]),  W'(tbl[k].s0));
        chk($sformatf("tbl%0d_s1", k), W'(osyn[15:8]), W'(tbl[k].s1));
      end
      step();
      chk($sformatf("tbl%0d_val_drop", k), W'(osyn_val), W'(1'b0));
    end

    // restart: isop at symbol 50 discards the partial frame
    for (int i = 0; i < 50; i++) drive_sym(8'($urandom), i == 0, 1'b0);
    fill(3, 255);
    send_frame(255);
    chk_result("restart", 255, 1'b0);
    step();

    // back-pressure: hold 10 cycles, then ack together with a new isop
    iack = 1'b0;
    fill(3, 255);
    r1 = ref_syn(255);
    send_frame(255);
    chk_result("hold0", 255, 1'b0);
    for (int c = 0; c < 10; c++) begin
      step();
      chk($sformatf("hold_rdy%0d", c), W'(ordy),     W'(1'b0));
      chk($sformatf("hold_val%0d", c), W'(osyn_val), W'(1'b1));
      chk($sformatf("hold_syn%0d", c), osyn,         r1);
    end
    fill(3, 255);
    iack = 1'b1;
    drive_sym(fr[0], 1'b1, 1'b0);
    chk("b2b_val_drop", W'(osyn_val), W'(1'b0));
    for (int i = 1; i < 255; i++) drive_sym(fr[i], 1'b0, i == 254);
    chk_result("b2b", 255, 1'b0);
    step();

    // reset abort at symbol 120
    fill(3, 255);
    for (int i = 0; i < 120; i++) drive_sym(fr[i], i == 0, 1'b0);
    ireset_n = 1'b0;
    #2;
    chk("abort_val", W'(osyn_val), W'(1'b0));
    chk("abort_syn", osyn,         '0);
    chk("abort_rdy", W'(ordy),     W'(1'b1));
    step();
    ireset_n = 1'b1;
    step();
    chk("abort_val2", W'(osyn_val), W'(1'b0));
    fill(3, 255);
    send_frame(255);
    chk_result("post_abort", 255, 1'b0);
    step();

    // random clock enable gives the same result as a free-running clock
    en_rand = 1'b1;
    send_frame(255);
    en_rand = 1'b0;
    chk_result("clkena", 255, 1'b0);
    iclkena = 1'b0;
    step(); step(); step();
    chk("clkena_freeze", W'(osyn_val), W'(1'b1));
    iclkena = 1'b1;
    step();
    chk("clkena_release", W'(osyn_val), W'(1'b0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rs_syndrome_ctrl.md
Name: rs_syndrome_ctrl

Overview:
Sequenced syndrome generator for the RS decoder front end. It accepts one codeword symbol per valid cycle and runs 2t parallel Horner accumulators, each built on a constant GF multiplier by alpha^(gen_start+j). It frames codewords with sop/eop, checks the codeword length, and presents the syndrome vector to the key-equation solver through a valid/ack handshake with back-pressure.

Parameters:
m, 8, symbol width in bits
irrpol, 285, field generator polynomial
n, 255, codeword length in symbols, 1..2^m-1
check, 32, number of syndromes (2t)
gen_start, 0, power of the first generator root; syndrome j uses alpha^(gen_start+j)

Ports:
iclk  in  1  clock
ireset_n  in  1  asynchronous active-low reset
iclkena  in  1  clock enable; gates every state update
isop  in  1  first symbol of codeword, qualified by ival
ieop  in  1  last symbol of codeword, qualified by ival
ival  in  1  symbol valid
idat  in  m  symbol, highest-degree coefficient first
ordy  out  1  block can accept a symbol this cycle
osyn_val  out  1  syndrome vector valid
osyn  out  check*m  syndromes; S_j occupies bits [j*m +: m]
osyn_zero  out  1  all syndromes zero (no detectable error), valid with osyn_val
oerr_len  out  1  symbol count at eop was not n, valid with osyn_val
iack  in  1  consumer accepts the syndrome vector

Behaviour:
- Reset (async, ireset_n=0): state IDLE; accumulators, counter, osyn, osyn_val, osyn_zero and oerr_len all 0. ordy=1 after reset.
- A symbol is accepted when iclkena & ival & ordy. Nothing changes when iclkena=0.
- ordy = (state != HOLD) | iack. This allows back-to-back frames in the cycle the held vector is acked.
- States:
  - IDLE: an accepted symbol with isop loads S_j <= idat for all j and cnt <= 1, then goes to ACC. An accepted symbol without isop is dropped and the state stays IDLE.
  - ACC: each accepted symbol updates S_j <= gf_mult(S_j, alpha^(gen_start+j)) xor idat and cnt <= cnt+1. An accepted isop restarts the frame: S_j <= idat, cnt <= 1, and the old partial frame is discarded with no flag.
  - On an accepted ieop (in IDLE with isop, or in ACC), the final update is applied and the state goes to HOLD. osyn_val=1 from the next cycle.
  - HOLD: osyn, osyn_zero and oerr_len are stable while iack=0.
    - iack=1 with no accepted isop: osyn_val=0 next cycle, state IDLE.
    - iack=1 with accepted isop in the same cycle: start the new frame (load as above), state ACC or HOLD if ieop is also set, osyn_val follows.
- isop&ieop on the same accepted symbol forms a 1-symbol frame: S_j=idat, oerr_len = (n!=1).
- oerr_len = (final cnt != n). cnt saturates at 2^ceil(log2(n+1))-1, so an overlong frame still reports an error. Syndromes are reported regardless of oerr_len.
- osyn_zero = ~|osyn, registered with osyn.
- Latency: ieop accept to osyn_val is 1 cycle.
- Constant multiplies use the shared GF constant-multiply function. The multipliers are combinational; only the accumulators and control are registered.
- ireset_n low mid-frame or in HOLD aborts immediately to the reset state. No partial result is ever flagged valid.

Test Plan:
- All-zero 255-symbol codeword, iack tied 1 -> osyn_val one cycle after eop, every S_j=0x00, osyn_zero=1, oerr_len=0.
- Codeword zero except last symbol 0x05 -> every S_j=0x05, osyn_zero=0.
- Codeword zero except first symbol 0x01, gen_start=0 -> S_0=0x01, S_1=0x8E (alpha^254), S_j=alpha^(-j).
- ieop on symbol 100 -> oerr_len=1, syndromes still computed. Then a 300-symbol frame -> oerr_len=1. Then isop at symbol 50 followed by a full 255-symbol frame -> oerr_len=0, result equals the clean frame.
- iack held 0 for 10 cycles in HOLD -> ordy=0 and osyn stable for all 10 cycles. iack=1 with isop in the same cycle -> new frame accepted, two back-to-back frames give correct independent results.
- ireset_n pulsed low at symbol 120, then a clean frame -> no osyn_val for the aborted frame, correct syndromes for the new one. Toggling iclkena=0 for random cycles gives results identical to the iclkena=1 run.
